// File: rtl/toy_bus_ddec_node_ack_buf.sv
// ============================================================================
// Module  : toy_bus_ddec_node_ack_buf
// Brief   : 2-entry elastic ack buffer that routes each flit by tgt_id to
//           one of two arbiter inputs. Optional tgt_id legality check is
//           enabled by defining TOY_BUS_DDEC_ERR_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module toy_bus_ddec_node_ack_buf #(
  parameter int                      DATA_W        = 256,
  parameter int                      SB_W          = 10,
  parameter int                      ID_W          = 4,
  parameter logic [(1<<ID_W)-1:0]    OUT1_TGT_MAP  = 16'h0000,
  parameter logic [(1<<ID_W)-1:0]    VALID_TGT_MAP = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [SB_W-1:0]   in0_sideband,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic              out0_opcode,
  output logic [DATA_W-1:0] out0_data,
  output logic [SB_W-1:0]   out0_sideband,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id,
  output logic              out1_vld,
  input  logic              out1_rdy,
  output logic              out1_opcode,
  output logic [DATA_W-1:0] out1_data,
  output logic [SB_W-1:0]   out1_sideband,
  output logic [ID_W-1:0]   out1_src_id,
  output logic [ID_W-1:0]   out1_tgt_id,
  output logic              err_unmapped
);

  logic              opcode_q   [2];
  logic [DATA_W-1:0] data_q     [2];
  logic [SB_W-1:0]   sideband_q [2];
  logic [ID_W-1:0]   src_id_q   [2];
  logic [ID_W-1:0]   tgt_id_q   [2];
  logic              route_q    [2];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       rdy_q,    rdy_d;
  logic       err_q,    err_d;

  logic w_push;
  logic w_legal;
  logic w_wr;
  logic w_pop;
  logic w_head_route;

  assign w_push = in0_vld & rdy_q;

`ifdef TOY_BUS_DDEC_ERR_CHK_EN
  assign w_legal = VALID_TGT_MAP[in0_tgt_id];
`else
  logic w_unused_valid_map;
  assign w_unused_valid_map = ^VALID_TGT_MAP;
  assign w_legal            = 1'b1;
`endif

  // An illegal flit is still handshaken upstream, it just never lands in storage.
  assign w_wr         = w_push & w_legal;
  assign w_head_route = route_q[rd_ptr_q];

  assign out0_vld = (count_q != 2'd0) & ~w_head_route;
  assign out1_vld = (count_q != 2'd0) &  w_head_route;
  assign w_pop    = (out0_vld & out0_rdy) | (out1_vld & out1_rdy);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (w_wr)  wr_ptr_d = ~wr_ptr_q;
    if (w_pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({w_wr, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    rdy_d = (count_d < 2'd2);
`ifdef TOY_BUS_DDEC_ERR_CHK_EN
    if (w_push & ~w_legal) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        opcode_q[i]   <= 1'b0;
        data_q[i]     <= '0;
        sideband_q[i] <= '0;
        src_id_q[i]   <= '0;
        tgt_id_q[i]   <= '0;
        route_q[i]    <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      if (w_wr) begin
        opcode_q[wr_ptr_q]   <= in0_opcode;
        data_q[wr_ptr_q]     <= in0_data;
        sideband_q[wr_ptr_q] <= in0_sideband;
        src_id_q[wr_ptr_q]   <= in0_src_id;
        tgt_id_q[wr_ptr_q]   <= in0_tgt_id;
        route_q[wr_ptr_q]    <= OUT1_TGT_MAP[in0_tgt_id];
      end
    end
  end

  assign in0_rdy      = rdy_q;
  assign err_unmapped = err_q;

  // Both ports always present the head; only the matching vld qualifies it.
  assign out0_opcode   = opcode_q[rd_ptr_q];
  assign out0_data     = data_q[rd_ptr_q];
  assign out0_sideband = sideband_q[rd_ptr_q];
  assign out0_src_id   = src_id_q[rd_ptr_q];
  assign out0_tgt_id   = tgt_id_q[rd_ptr_q];
  assign out1_opcode   = opcode_q[rd_ptr_q];
  assign out1_data     = data_q[rd_ptr_q];
  assign out1_sideband = sideband_q[rd_ptr_q];
  assign out1_src_id   = src_id_q[rd_ptr_q];
  assign out1_tgt_id   = tgt_id_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_toy_bus_ddec_node_ack_buf.sv
// Testbench for toy_bus_ddec_node_ack_buf: directed scenarios plus random
// traffic checked against a queue-based reference model.
`default_nettype none

module tb_toy_bus_ddec_node_ack_buf;

  localparam int          DATA_W   = 256;
  localparam int          SB_W     = 10;
  localparam int          ID_W     = 4;
  localparam logic [15:0] OUT1_MAP = 16'h0004;
  localparam logic [15:0] VLD_MAP  = 16'h0005;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in0_vld, in0_rdy, in0_opcode;
  logic [DATA_W-1:0] in0_data;
  logic [SB_W-1:0]   in0_sideband;
  logic [ID_W-1:0]   in0_src_id, in0_tgt_id;
  logic              out0_vld, out0_rdy, out0_opcode;
  logic [DATA_W-1:0] out0_data;
  logic [SB_W-1:0]   out0_sideband;
  logic [ID_W-1:0]   out0_src_id, out0_tgt_id;
  logic              out1_vld, out1_rdy, out1_opcode;
  logic [DATA_W-1:0] out1_data;
  logic [SB_W-1:0]   out1_sideband;
  logic [ID_W-1:0]   out1_src_id, out1_tgt_id;
  logic              err_unmapped;

  toy_bus_ddec_node_ack_buf #(
    .DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W),
    .OUT1_TGT_MAP(OUT1_MAP), .VALID_TGT_MAP(VLD_MAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_opcode(in0_opcode),
    .in0_data(in0_data), .in0_sideband(in0_sideband),
    .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
    .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_opcode(out0_opcode),
    .out0_data(out0_data), .out0_sideband(out0_sideband),
    .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
    .out1_vld(out1_vld), .out1_rdy(out1_rdy), .out1_opcode(out1_opcode),
    .out1_data(out1_data), .out1_sideband(out1_sideband),
    .out1_src_id(out1_src_id), .out1_tgt_id(out1_tgt_id),
    .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              route;
    logic              op;
    logic [DATA_W-1:0] data;
    logic [SB_W-1:0]   sb;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
  } flit_t;

  flit_t q[$];
  logic  m_err;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic tgt_legal(input logic [ID_W-1:0] t);
`ifdef TOY_BUS_DDEC_ERR_CHK_EN
    return ((VLD_MAP >> t) & 16'd1) != 16'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_outputs();
    logic nonempty;
    nonempty = (q.size() != 0);
    check("in0_rdy",      in0_rdy,      q.size() < 2);
    check("out0_vld",     out0_vld,     nonempty && q[0].route == 1'b0);
    check("out1_vld",     out1_vld,     nonempty && q[0].route == 1'b1);
    check("err_unmapped", err_unmapped, m_err);
    if (nonempty) begin
      if (q[0].route) begin
        check("out1_data", out1_data,   q[0].data);
        check("out1_meta", {out1_opcode, out1_sideband, out1_src_id, out1_tgt_id},
                           {q[0].op, q[0].sb, q[0].src, q[0].tgt});
      end else begin
        check("out0_data", out0_data,   q[0].data);
        check("out0_meta", {out0_opcode, out0_sideband, out0_src_id, out0_tgt_id},
                           {q[0].op, q[0].sb, q[0].src, q[0].tgt});
      end
    end
  endtask

  // Drive one cycle from a negedge, check, apply the model at the posedge.
  task automatic tick(input logic v, input logic [ID_W-1:0] tgt,
                      input logic [DATA_W-1:0] d, input logic r0, input logic r1);
    flit_t f;
    logic  m_push, m_pop;
    in0_vld      = v;
    in0_tgt_id   = tgt;
    in0_data     = d;
    in0_opcode   = 1'($urandom);
    in0_sideband = SB_W'($urandom);
    in0_src_id   = ID_W'($urandom);
    out0_rdy     = r0;
    out1_rdy     = r1;
    #1;
    check_outputs();
    m_push = v && (q.size() < 2);
    m_pop  = (q.size() != 0) && (q[0].route ? r1 : r0);
    f = '{route: ((OUT1_MAP >> tgt) & 16'd1) != 16'd0, op: in0_opcode, data: d,
          sb: in0_sideband, src: in0_src_id, tgt: tgt};
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_push) begin
      if (tgt_legal(tgt)) q.push_back(f);
      else                m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check("rst_in0_rdy",  in0_rdy,      1'b1);
    check("rst_out_vld",  {out0_vld, out1_vld}, 2'b00);
    check("rst_err",      err_unmapped, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_err = 1'b0;
    in0_vld = 1'b0; in0_opcode = 1'b0; in0_data = '0; in0_sideband = '0;
    in0_src_id = '0; in0_tgt_id = '0; out0_rdy = 1'b0; out1_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (2) tick(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Single flit to out1, popped immediately
    tick(1'b1, 4'd2, 256'hA5, 1'b1, 1'b1);
    check("a5_out1_vld",  out1_vld,  1'b1);
    check("a5_out0_vld",  out0_vld,  1'b0);
    check("a5_out1_data", out1_data, 256'hA5);
    tick(1'b0, 4'd0, '0, 1'b1, 1'b1);
    check("a5_popped", out1_vld, 1'b0);

    // Back-pressure on out0: fills, stalls, then drains
    tick(1'b1, 4'd0, rand_data(), 1'b0, 1'b1);
    tick(1'b1, 4'd0, rand_data(), 1'b0, 1'b1);
    check("full_rdy_low", in0_rdy, 1'b0);
    tick(1'b1, 4'd0, rand_data(), 1'b0, 1'b1);
    tick(1'b1, 4'd0, in0_data,    1'b1, 1'b1);
    check("full_rdy_back", in0_rdy, 1'b1);
    repeat (4) tick(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Sustained streaming alternating routes
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i % 2) ? 4'd2 : 4'd0, rand_data(), 1'b1, 1'b1);
      check("stream_rdy", in0_rdy, 1'b1);
    end
    tick(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Head-of-line blocking
    tick(1'b1, 4'd0, rand_data(), 1'b0, 1'b1);
    tick(1'b1, 4'd2, rand_data(), 1'b0, 1'b1);
    repeat (3) begin
      tick(1'b0, 4'd0, '0, 1'b0, 1'b1);
      check("hol_out1_blocked", out1_vld, 1'b0);
    end
    tick(1'b0, 4'd0, '0, 1'b1, 1'b1);
    check("hol_out1_released", out1_vld, 1'b1);
    tick(1'b0, 4'd0, '0, 1'b1, 1'b1);

`ifdef TOY_BUS_DDEC_ERR_CHK_EN
    tick(1'b1, 4'd1, rand_data(), 1'b1, 1'b1);
    check("err_set",       err_unmapped, 1'b1);
    check("err_no_vld",    {out0_vld, out1_vld}, 2'b00);
    repeat (3) tick(1'b0, 4'd0, '0, 1'b1, 1'b1);
    check("err_sticky",    err_unmapped, 1'b1);
`endif

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        tick(1'b1, 4'd0, rand_data(), 1'b0, 1'b0);
        tick(1'b1, 4'd2, rand_data(), 1'b0, 1'b0);
        do_reset();
      end
      tick(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? 4'd2 : ID_W'($urandom),
           rand_data(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
